// File: rtl/counter_pkg.sv
// Shared definitions for the counter peripheral family: register map indices,
// control/status bit positions and default widths.
package counter_pkg;

  localparam int CNT_W_DEFAULT  = 32;
  localparam int MCNT_W_DEFAULT = 16;

  localparam logic [3:0] REG_CTRL   = 4'd0;
  localparam logic [3:0] REG_CMP    = 4'd1;
  localparam logic [3:0] REG_DUTY   = 4'd2;
  localparam logic [3:0] REG_STATUS = 4'd3;
  localparam logic [3:0] REG_MCOUNT = 4'd4;

  localparam int CTRL_W       = 5;
  localparam int CTRL_CMP_EN  = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_PWM_EN  = 2;
  localparam int CTRL_PWM_POL = 3;
  localparam int CTRL_ONESHOT = 4;

  localparam int STAT_MATCH  = 0;
  localparam int STAT_MISSED = 1;

endpackage

// File: rtl/cmp_match_detect.sv
// Registers the live count and flags the first cycle in which it equals the
// compare value, so a stalled counter produces a single event.
module cmp_match_detect
  import counter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cmp_en,
  input  logic [CNT_W-1:0] cmp_val,
  input  logic [CNT_W-1:0] cnt_val,
  output logic             match_evt
);

  logic [CNT_W-1:0] cnt_q;

  // Previous-cycle count for the equality edge detector.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_val;
    end
  end

  assign match_evt = cmp_en & (cnt_val == cmp_val) & (cnt_q != cmp_val);

endmodule

// File: rtl/counter_compare.sv
// Compare/PWM stage behind the counter peripheral: sticky maskable match
// interrupt, match counter and PWM output on the PicoSoC register bus.
module counter_compare
  import counter_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEFAULT,
  parameter int MCNT_W = MCNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [3:0]       reg_we,
  input  logic [3:0]       reg_re,
  input  logic [3:0]       reg_addr,
  input  logic [31:0]      reg_di,
  output logic [31:0]      reg_do,
  output logic             ready,
  input  logic [CNT_W-1:0] cnt_val,
  output logic             irq,
  output logic             pwm_out
);

  logic [CTRL_W-1:0] ctrl_r;
  logic [CTRL_W-1:0] ctrl_s;
  logic [CNT_W-1:0]  cmp_r;
  logic [CNT_W-1:0]  duty_r;
  logic              match_r;
  logic              missed_r;
  logic              match_s;
  logic              missed_s;
  logic [MCNT_W-1:0] mcount_r;
  logic [MCNT_W-1:0] mcount_s;
  logic              access_s;
  logic              wr_s;
  logic              rd_s;
  logic              clr_match_s;
  logic              clr_missed_s;
  logic              match_evt_s;
  logic [31:0]       rdata_s;

  // The cycle carrying ready never starts a new access, so held strobes act once.
  assign access_s     = ((|reg_we) | (|reg_re)) & ~ready;
  assign wr_s         = access_s & (|reg_we);
  assign rd_s         = access_s & (|reg_re);
  assign clr_match_s  = wr_s & (reg_addr == REG_STATUS) & reg_di[STAT_MATCH];
  assign clr_missed_s = wr_s & (reg_addr == REG_STATUS) & reg_di[STAT_MISSED];

  cmp_match_detect #(
    .CNT_W(CNT_W)
  ) u_match (
    .clk      (clk),
    .resetn   (resetn),
    .cmp_en   (ctrl_r[CTRL_CMP_EN]),
    .cmp_val  (cmp_r),
    .cnt_val  (cnt_val),
    .match_evt(match_evt_s)
  );

  // A new match beats a same-cycle W1C; MISSED only sets if MATCH survives the clear.
  assign match_s  = (match_r & ~clr_match_s) | match_evt_s;
  assign missed_s = (missed_r & ~clr_missed_s) | (match_evt_s & match_r & ~clr_match_s);

  // Next CTRL and MCOUNT; bus writes take priority over event-driven updates.
  always_comb begin
    ctrl_s   = ctrl_r;
    mcount_s = mcount_r;
    if (wr_s && (reg_addr == REG_CTRL)) begin
      ctrl_s = reg_di[CTRL_W-1:0];
    end else if (match_evt_s && ctrl_r[CTRL_ONESHOT]) begin
      ctrl_s              = ctrl_r;
      ctrl_s[CTRL_CMP_EN] = 1'b0;
    end else begin
      ctrl_s = ctrl_r;
    end
    if (wr_s && (reg_addr == REG_MCOUNT)) begin
      mcount_s = {MCNT_W{1'b0}};
    end else if (match_evt_s) begin
      mcount_s = mcount_r + MCNT_W'(1);
    end else begin
      mcount_s = mcount_r;
    end
  end

  // Read data multiplexer.
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (reg_addr)
      REG_CTRL:   rdata_s = 32'(ctrl_r);
      REG_CMP:    rdata_s = 32'(cmp_r);
      REG_DUTY:   rdata_s = 32'(duty_r);
      REG_STATUS: rdata_s = {30'd0, missed_r, match_r};
      REG_MCOUNT: rdata_s = 32'(mcount_r);
      default:    rdata_s = 32'h0000_0000;
    endcase
  end

  // Register file, bus response and registered irq/pwm outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ctrl_r   <= {CTRL_W{1'b0}};
      cmp_r    <= {CNT_W{1'b0}};
      duty_r   <= {CNT_W{1'b0}};
      match_r  <= 1'b0;
      missed_r <= 1'b0;
      mcount_r <= {MCNT_W{1'b0}};
      ready    <= 1'b0;
      reg_do   <= 32'h0000_0000;
      irq      <= 1'b0;
      pwm_out  <= 1'b0;
    end else begin
      ctrl_r   <= ctrl_s;
      match_r  <= match_s;
      missed_r <= missed_s;
      mcount_r <= mcount_s;
      if (wr_s && (reg_addr == REG_CMP)) begin
        cmp_r <= reg_di[CNT_W-1:0];
      end else begin
        cmp_r <= cmp_r;
      end
      if (wr_s && (reg_addr == REG_DUTY)) begin
        duty_r <= reg_di[CNT_W-1:0];
      end else begin
        duty_r <= duty_r;
      end
      ready   <= access_s;
      reg_do  <= rd_s ? rdata_s : 32'h0000_0000;
      irq     <= ctrl_s[CTRL_IRQ_EN] & (match_s | missed_s);
      pwm_out <= ctrl_r[CTRL_PWM_EN] ? ((cnt_val < duty_r) ^ ctrl_r[CTRL_PWM_POL])
                                     : ctrl_r[CTRL_PWM_POL];
    end
  end

endmodule

// File: tb/tb_counter_compare.sv
// Self-checking bench for counter_compare: directed scenarios plus randomized
// traffic, all compared against a behavioural model of the register map.
module tb_counter_compare;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  reg_we, reg_re, reg_addr;
  logic [31:0] reg_di, reg_do, cnt_val;
  logic        ready, irq, pwm_out;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  logic [4:0]  m_ctrl;
  logic [31:0] m_cmp, m_duty, m_prev_cnt;
  logic        m_match, m_missed, m_ready;
  logic [15:0] m_mcount;
  logic [31:0] cur_cnt;

  always #5 clk = ~clk;

  counter_compare dut (
    .clk     (clk),
    .resetn  (resetn),
    .reg_we  (reg_we),
    .reg_re  (reg_re),
    .reg_addr(reg_addr),
    .reg_di  (reg_di),
    .reg_do  (reg_do),
    .ready   (ready),
    .cnt_val (cnt_val),
    .irq     (irq),
    .pwm_out (pwm_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] a);
    case (a)
      4'd0:    return {27'd0, m_ctrl};
      4'd1:    return m_cmp;
      4'd2:    return m_duty;
      4'd3:    return {30'd0, m_missed, m_match};
      4'd4:    return {16'd0, m_mcount};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_ctrl = 5'd0; m_cmp = 32'd0; m_duty = 32'd0; m_prev_cnt = 32'd0;
    m_match = 1'b0; m_missed = 1'b0; m_ready = 1'b0; m_mcount = 16'd0;
  endtask

  // One bus/count cycle: drive at negedge, predict, check 1ns after the posedge.
  task automatic step(input logic [3:0] we, input logic [3:0] re, input logic [3:0] a,
                      input logic [31:0] di, input logic [31:0] cnt);
    bit req, wr, rd, evt, clr_m, clr_x, was_match, exp_pwm, exp_irq;
    logic [31:0] exp_do;
    @(negedge clk);
    reg_we = we; reg_re = re; reg_addr = a; reg_di = di; cnt_val = cnt; cur_cnt = cnt;
    req    = ((we != 4'd0) || (re != 4'd0)) && !m_ready;
    wr     = req && (we != 4'd0);
    rd     = req && (re != 4'd0);
    exp_do = rd ? m_read(a) : 32'd0;
    evt    = m_ctrl[0] && (cnt == m_cmp) && (m_prev_cnt != m_cmp);
    exp_pwm = m_ctrl[2] ? ((cnt < m_duty) ^ m_ctrl[3]) : m_ctrl[3];
    clr_m  = wr && (a == 4'd3) && di[0];
    clr_x  = wr && (a == 4'd3) && di[1];
    was_match = m_match && !clr_m;
    m_match   = was_match || evt;
    m_missed  = (m_missed && !clr_x) || (evt && was_match);
    if (wr && a == 4'd4) m_mcount = 16'd0;
    else if (evt) m_mcount = m_mcount + 16'd1;
    if (wr && a == 4'd0) m_ctrl = di[4:0];
    else if (evt && m_ctrl[4]) m_ctrl[0] = 1'b0;
    if (wr && a == 4'd1) m_cmp = di;
    if (wr && a == 4'd2) m_duty = di;
    exp_irq    = m_ctrl[1] && (m_match || m_missed);
    m_prev_cnt = cnt;
    m_ready    = req;
    @(posedge clk); #1;
    chk("ready", {31'd0, ready}, {31'd0, req});
    chk("reg_do", reg_do, exp_do);
    chk("irq", {31'd0, irq}, {31'd0, exp_irq});
    chk("pwm_out", {31'd0, pwm_out}, {31'd0, exp_pwm});
  endtask

  task automatic idle();
    step(4'd0, 4'd0, 4'd0, 32'd0, cur_cnt);
  endtask

  task automatic run_cnt(input logic [31:0] v);
    step(4'd0, 4'd0, 4'd0, 32'd0, v);
  endtask

  task automatic ramp(input int lo, input int hi);
    for (int v = lo; v <= hi; v++) run_cnt(32'(v));
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
    step(4'hF, 4'd0, a, d, cur_cnt);
    idle();
  endtask

  task automatic rd_expect(input string tag, input logic [3:0] a, input logic [31:0] exp);
    step(4'd0, 4'hF, a, 32'd0, cur_cnt);
    chk(tag, reg_do, exp);
    idle();
  endtask

  task automatic random_phase(input int n);
    int op, r;
    logic [3:0] a, we, re;
    logic [31:0] d, c;
    for (int i = 0; i < n; i++) begin
      op = $urandom_range(0, 9);
      a  = 4'($urandom_range(0, 6));
      case (a)
        4'd0:       d = $urandom & 32'h1F;
        4'd1, 4'd2: d = 32'($urandom_range(0, 15));
        default:    d = $urandom;
      endcase
      we = (op == 0 || op == 2) ? 4'($urandom_range(1, 15)) : 4'd0;
      re = (op == 1 || op == 2) ? 4'($urandom_range(1, 15)) : 4'd0;
      r  = $urandom_range(0, 9);
      if (r < 5)       c = (cur_cnt + 32'd1) & 32'hF;
      else if (r < 8)  c = cur_cnt;
      else if (r == 8) c = 32'($urandom_range(0, 15));
      else             c = $urandom;
      step(we, re, a, d, c);
    end
  endtask

  initial begin
    int hi;
    resetn = 1'b0; reg_we = 4'd0; reg_re = 4'd0; reg_addr = 4'd0; reg_di = 32'd0;
    cnt_val = 32'd0; cur_cnt = 32'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_pwm", {31'd0, pwm_out}, 32'd0);
    chk("rst_do", reg_do, 32'd0);
    @(negedge clk) resetn = 1'b1;

    for (int a = 0; a < 6; a++) rd_expect("reset_read", 4'(a), 32'd0);

    // Single match with a stalled counter
    wr_reg(4'd1, 32'd5);
    wr_reg(4'd0, 32'h3);
    ramp(0, 4);
    chk("t2_irq_low", {31'd0, irq}, 32'd0);
    run_cnt(32'd5);
    chk("t2_irq_rise", {31'd0, irq}, 32'd1);
    repeat (3) run_cnt(32'd5);
    ramp(6, 10);
    rd_expect("t2_status", 4'd3, 32'h1);
    rd_expect("t2_mcount", 4'd4, 32'd1);
    step(4'hF, 4'd0, 4'd3, 32'h1, cur_cnt);
    chk("t2_irq_fall", {31'd0, irq}, 32'd0);
    idle();

    // Two matches without clearing, then W1C colliding with a match
    wr_reg(4'd4, 32'd0);
    ramp(0, 10);
    ramp(0, 10);
    rd_expect("t3_status", 4'd3, 32'h3);
    rd_expect("t3_mcount", 4'd4, 32'd2);
    wr_reg(4'd3, 32'h3);
    ramp(0, 5);
    run_cnt(32'd4);
    step(4'hF, 4'd0, 4'd3, 32'h1, 32'd5);
    idle();
    rd_expect("t3_w1c_vs_match", 4'd3, 32'h1);
    rd_expect("t3_mcount4", 4'd4, 32'd4);

    // One-shot
    wr_reg(4'd3, 32'h3);
    wr_reg(4'd4, 32'd0);
    run_cnt(32'd0);
    wr_reg(4'd1, 32'd3);
    wr_reg(4'd0, 32'h13);
    ramp(0, 6);
    ramp(0, 6);
    rd_expect("t4_ctrl", 4'd0, 32'h12);
    rd_expect("t4_mcount", 4'd4, 32'd1);

    // PWM
    wr_reg(4'd2, 32'd4);
    wr_reg(4'd0, 32'h4);
    hi = 0;
    for (int v = 0; v < 10; v++) begin run_cnt(32'(v)); hi += int'(pwm_out); end
    chk("t5_pwm_high", 32'(hi), 32'd4);
    wr_reg(4'd0, 32'hC);
    hi = 0;
    for (int v = 0; v < 10; v++) begin run_cnt(32'(v)); hi += int'(pwm_out); end
    chk("t5_pwm_inv_high", 32'(hi), 32'd6);
    wr_reg(4'd0, 32'h8);
    idle();
    chk("t5_pwm_idle_pol", {31'd0, pwm_out}, 32'd1);

    // Count wrap through CMP=0
    wr_reg(4'd1, 32'd0);
    wr_reg(4'd4, 32'd0);
    wr_reg(4'd3, 32'h3);
    run_cnt(32'hFFFF_FFF0);
    wr_reg(4'd0, 32'h1);
    run_cnt(32'hFFFF_FFFE); run_cnt(32'hFFFF_FFFF);
    run_cnt(32'd0); run_cnt(32'd0); run_cnt(32'd1);
    rd_expect("t6_wrap_mcount", 4'd4, 32'd1);

    random_phase(3000);

    // Reset while a read is pending, with STATUS=3 and irq high
    wr_reg(4'd3, 32'h3);
    run_cnt(32'd9);
    wr_reg(4'd1, 32'd2);
    wr_reg(4'd0, 32'h3);
    ramp(0, 4);
    ramp(0, 4);
    rd_expect("t7_status", 4'd3, 32'h3);
    chk("t7_irq_pre", {31'd0, irq}, 32'd1);
    @(negedge clk);
    reg_re = 4'hF; reg_addr = 4'd3;
    #2 resetn = 1'b0;
    #1;
    chk("t7_rst_ready", {31'd0, ready}, 32'd0);
    chk("t7_rst_irq", {31'd0, irq}, 32'd0);
    chk("t7_rst_do", reg_do, 32'd0);
    model_reset();
    @(negedge clk) reg_re = 4'd0;
    @(negedge clk) resetn = 1'b1;
    idle();
    idle();
    for (int a = 0; a < 5; a++) rd_expect("t7_post_read", 4'(a), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
